register_dump_scanner: RTL
==========================

# register_dump_scanner

Debug-port reader that sits beside the single-cycle CPU and scans its register file through the `readRegisterDebug` / `readDataDebug` port. On a `start` pulse it snapshots the CPU program counter, then walks register addresses FIRST_REG..LAST_REG, captures each value and streams the frame out over a valid/ready word interface. The frame feeds a trace sink or host link. The block owns the debug address while busy, replacing hand-driven debug reads in benches.

## Interface
- FIRST_REG, 0, first register index scanned (0..31)
- LAST_REG, 31, last register index scanned (FIRST_REG..31)
- SETTLE_CYCLES, 1, cycles `readRegisterDebug` is held before `readDataDebug` is captured (1..15)

- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a frame; sampled only in IDLE
- abort  input  1  synchronous frame abort
- pcIn  input  32  CPU `pcOut`, snapshotted on start acceptance
- readRegisterDebug  output  5  debug register address to CPU
- readDataDebug  input  32  debug register data from CPU (combinational in CPU)
- outValid  output  1  outData/outIndex valid
- outReady  input  1  sink accepts word
- outData  output  32  frame word
- outIndex  output  6  0..31 = register number; 6'h3F = PC header word
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse after final word accepted

## Operation
- Reset values: readRegisterDebug=0, outValid=0, outData=0, outIndex=0, busy=0, done=0; state IDLE; address counter=FIRST_REG; settle counter=0.
- States:
  - IDLE: start=1 → snapshot pcIn into outData, outIndex=6'h3F, go to HEADER.
  - HEADER: outValid=1. On handshake (outValid&&outReady at the edge), set readRegisterDebug=FIRST_REG, load settle counter, go to ADDR.
  - ADDR: readRegisterDebug stable. Count down SETTLE_CYCLES. On the last count, capture readDataDebug into outData, set outIndex={1'b0,addr}, go to SEND.
  - SEND: outValid=1. On handshake: if addr==LAST_REG go to DONE; else addr+1 → readRegisterDebug, reload settle, go to ADDR.
  - DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in HEADER, ADDR and SEND. busy=0 in IDLE and DONE.
- start is ignored outside IDLE, including during DONE. No queuing.
- Valid/ready rules:
  - While outValid=1 and outReady=0, outData and outIndex hold stable.
  - outValid never drops without a handshake, except on abort or rst.
  - outReady is a don't-care when outValid=0.
- abort=1 at any edge in HEADER/ADDR/SEND: next state IDLE, outValid=0, busy=0, no done pulse, partial frame discarded. abort has priority over a coincident handshake. abort in IDLE or DONE has no effect.
- rst mid-frame: all outputs return to reset values immediately (asynchronous). No resume.
- readRegisterDebug holds the last scanned address in IDLE/DONE. This is LAST_REG after a full frame.
- Address counter is 5 bits. LAST_REG=31 terminates by compare, never by wrap.
- Frame length is LAST_REG−FIRST_REG+2 words.

## Timing
- start sampled at edge N → outValid=1 with the header from cycle N+1.
- With outReady held 1:
  - Each register word takes SETTLE_CYCLES+1 cycles (ADDR cycles plus one SEND cycle).
  - Frame busy time is 1 + (LAST_REG−FIRST_REG+1)·(SETTLE_CYCLES+1) cycles.
  - Default parameters: 65 busy cycles, done in cycle 66 after start.
- readDataDebug is captured at the edge ending the final ADDR cycle. The CPU may write the register until that edge.
- Backpressure stretches only SEND/HEADER. ADDR timing is unaffected.

## Test plan
- Default params, outReady=1, CPU registers preloaded r[i]=i·0x11111111, pcOut=0x40, start pulse → 33 words: header 0x00000040/idx 3F, then r0..r31 in order; done pulses exactly 65 cycles after header.
- FIRST_REG=10, LAST_REG=10, SETTLE_CYCLES=3 → header plus a single word idx 10 = r10; readRegisterDebug=0xA held ≥3 cycles before capture.
- outReady randomly toggled, 40% duty → same 33-word sequence; outData/outIndex never change while outValid=1 and outReady=0.
- abort asserted during SEND of r5 with coincident outReady=1 → word not counted, outValid=0 next cycle, no done; a new start yields a full frame from the header.
- rst asserted mid-ADDR of r20 → outputs zero before the next edge; start during busy and during DONE ignored (frame count unchanged).

Source files
------------

// File: rtl/register_dump_scanner_if.sv
// ---------------------------------------------------------------------------
// register_dump_scanner_if
//   Bundles the control, CPU debug-port and frame-stream signals of the
//   register dump scanner.
//
//   slave  : the scanner itself (consumes start/abort/pcIn/readDataDebug/
//            outReady, drives the debug address and the frame stream)
//   master : whoever drives the scanner (CPU wrapper, trace sink, bench)
//
//   start             begin a frame (only honoured while idle)
//   abort             synchronous frame abort
//   pcIn              CPU program counter, snapshotted into the header word
//   readRegisterDebug debug register address presented to the CPU
//   readDataDebug     debug register data returned by the CPU
//   outValid/outReady word handshake
//   outData           frame word
//   outIndex          0..31 register number, 6'h3F for the PC header
//   busy              frame in progress
//   done              one-cycle pulse after the final word is accepted
// ---------------------------------------------------------------------------
interface register_dump_scanner_if;
    logic        start;
    logic        abort;
    logic [31:0] pcIn;
    logic [4:0]  readRegisterDebug;
    logic [31:0] readDataDebug;
    logic        outValid;
    logic        outReady;
    logic [31:0] outData;
    logic [5:0]  outIndex;
    logic        busy;
    logic        done;

    modport slave (
        input  start,
        input  abort,
        input  pcIn,
        input  readDataDebug,
        input  outReady,
        output readRegisterDebug,
        output outValid,
        output outData,
        output outIndex,
        output busy,
        output done
    );

    modport master (
        output start,
        output abort,
        output pcIn,
        output readDataDebug,
        output outReady,
        input  readRegisterDebug,
        input  outValid,
        input  outData,
        input  outIndex,
        input  busy,
        input  done
    );
endinterface

// File: rtl/register_dump_scanner.sv
// ---------------------------------------------------------------------------
// register_dump_scanner
//   Walks the CPU register file through its debug read port and streams a
//   frame of words: a PC header (index 6'h3F) followed by registers
//   FIRST_REG..LAST_REG in ascending order.
//
//   Parameters
//     FIRST_REG     first register index scanned (0..31)
//     LAST_REG      last register index scanned (FIRST_REG..31)
//     SETTLE_CYCLES cycles the debug address is held before capture (1..15)
//
//   Ports
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  register_dump_scanner_if.slave (see interface header)
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for start; debug address holds last scanned value
//   HEADER  | PC header word offered on the stream
//   ADDR    | debug address stable, settle counter running down
//   SEND    | captured register word offered on the stream
//   DONE    | one-cycle done pulse, start ignored
// ---------------------------------------------------------------------------
module register_dump_scanner #(
    parameter int unsigned FIRST_REG     = 0,
    parameter int unsigned LAST_REG      = 31,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    register_dump_scanner_if.slave bus
);

    localparam logic [4:0] FIRST_A   = FIRST_REG[4:0];
    localparam logic [4:0] LAST_A    = LAST_REG[4:0];
    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE_CYCLES - 1);
    localparam logic [5:0] PC_INDEX  = 6'h3F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_ADDR,
        S_SEND,
        S_DONE
    } state_t;

    state_t      state_q,  state_d;
    logic [4:0]  addr_q,   addr_d;
    logic [3:0]  settle_q, settle_d;
    logic [4:0]  dbg_q,    dbg_d;
    logic [31:0] data_q,   data_d;
    logic [5:0]  index_q,  index_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= FIRST_A;
            settle_q <= 4'd0;
            dbg_q    <= 5'd0;
            data_q   <= 32'd0;
            index_q  <= 6'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            settle_q <= settle_d;
            dbg_q    <= dbg_d;
            data_q   <= data_d;
            index_q  <= index_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        settle_d = settle_q;
        dbg_d    = dbg_q;
        data_d   = data_q;
        index_d  = index_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    data_d  = bus.pcIn;
                    index_d = PC_INDEX;
                    state_d = S_HEADER;
                end
            end

            // abort outranks a coincident handshake in every busy state
            S_HEADER: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (bus.outReady) begin
                    addr_d   = FIRST_A;
                    dbg_d    = FIRST_A;
                    settle_d = SETTLE_M1;
                    state_d  = S_ADDR;
                end
            end

            // settle counter is loaded with SETTLE_CYCLES-1 so the address is
            // presented for exactly SETTLE_CYCLES cycles before capture
            S_ADDR: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (settle_q == 4'd0) begin
                    data_d  = bus.readDataDebug;
                    index_d = {1'b0, addr_q};
                    state_d = S_SEND;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end

            // termination is by compare, so LAST_REG=31 never wraps to 0
            S_SEND: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (bus.outReady) begin
                    if (addr_q == LAST_A) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d   = addr_q + 5'd1;
                        dbg_d    = addr_q + 5'd1;
                        settle_d = SETTLE_M1;
                        state_d  = S_ADDR;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // handshake-facing outputs come straight from registered state
    assign bus.outValid          = (state_q == S_HEADER) || (state_q == S_SEND);
    assign bus.busy              = (state_q == S_HEADER) || (state_q == S_ADDR) ||
                                   (state_q == S_SEND);
    assign bus.done              = (state_q == S_DONE);
    assign bus.readRegisterDebug = dbg_q;
    assign bus.outData           = data_q;
    assign bus.outIndex          = index_q;

endmodule
